dcache_mem_responder: RTL and testbench
=======================================

# dcache_mem_responder

Memory-side responder for the data cache line-transfer protocol. Accepts line read (allocate) and line write (write-back) requests from the data cache controller, models a word-wide backing memory with a programmable access latency, and returns a single-cycle acknowledge per completed transaction. Sits between the data cache and the data memory array and honours the controller's kill signal.

## Interface
Parameters:
- WORD_W, 32, width of one memory word in bits.
- LINE_WORDS, 4, words per cache line; power of 2, ≥2.
- ADDR_W, 32, byte address width.
- MEM_WORDS, 1024, backing memory depth in words; power of 2.
- RD_LATENCY, 2, idle cycles between accept and first word transfer; range 0–15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- dcache2mem_req_i  in  1  request; held high by the initiator until ack.
- dcache2mem_wr_i  in  1  1 = line write, 0 = line read; sampled at accept.
- dcache2mem_kill_i  in  1  abort the current transaction.
- dcache2mem_addr_i  in  ADDR_W  byte address; line-offset bits ignored.
- dcache2mem_wdata_i  in  LINE_WORDS*WORD_W  write line; word 0 in LSBs; sampled at accept.
- mem2dcache_rdata_o  out  LINE_WORDS*WORD_W  read line; valid in the ack cycle, held until the next accepted read.
- mem2dcache_ack_o  out  1  single-cycle completion pulse.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, XFER, ACK.
- IDLE: when req=1 and kill=0, accept: capture wr, line base word index, and wdata into an internal line buffer; go to WAIT (to XFER if RD_LATENCY=0); load latency counter with RD_LATENCY-1.
- WAIT: count down; on counter=0 go to XFER with beat counter=0.
- XFER: one word per cycle. Word index = ((addr >> log2(WORD_W/8)) with low log2(LINE_WORDS) bits replaced by beat) mod MEM_WORDS. Read: memory word → line buffer slot [beat]. Write: line buffer slot [beat] → memory. Beat LINE_WORDS-1 → ACK.
- ACK: mem2dcache_ack_o=1 for exactly one cycle; read data in the line buffer drive mem2dcache_rdata_o; return to IDLE. Req is ignored during the ACK cycle; a back-to-back request (e.g. write-back followed by allocate) is accepted the cycle after ack at the earliest.
- Abort: kill=1, or req=0 in WAIT/XFER, forces IDLE next cycle with no ack. Words already written during XFER stay written; partial read data are discarded (rdata_o keeps the previous completed line). Kill in ACK cycle: ack still asserted (transaction already complete).
- Kill and req both high in IDLE: no accept.
- Address beyond MEM_WORDS wraps modulo MEM_WORDS. Misaligned addresses are aligned to the line base.
- Backing memory is not reset; contents are undefined until written.

## Timing
- Reset values: mem2dcache_ack_o=0, mem2dcache_rdata_o=0, busy_o=0, state IDLE, counters 0.
- Reset asserted mid-transaction: IDLE next edge, no ack, line buffer cleared.
- Accept at edge T (req sampled high in IDLE). ack high during cycle T+RD_LATENCY+LINE_WORDS+1 relative to accept cycle as cycle 0; default 2+4+1 = cycle 7 after the accepting cycle... precisely: accept cycle is cycle 0, ack is visible in cycle RD_LATENCY+LINE_WORDS+1 (default 7).
- Minimum spacing between two acks: RD_LATENCY+LINE_WORDS+2 cycles (default 8).
- busy_o high from the cycle after accept through the ack cycle inclusive.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Write then read: write line {0x11111111,0x22222222,0x33333333,0x44444444} to addr 0x100, then read 0x100 -> ack in cycle 7 each, rdata equals written line, word 0 in LSBs.
- Back-to-back: write-back to 0x200 with req held high through ack and immediately a read of 0x300 -> second request accepted cycle after first ack; two acks exactly 8 cycles apart.
- Kill mid-write: write 0xAAAA_xxxx line to 0x400, assert kill in XFER beat 2 -> no ack, busy_o low next cycle; subsequent read shows words 0–1 new, 2–3 old.
- Req drop in WAIT: read 0x500, deassert req in cycle 1 -> no ack, rdata_o unchanged, next request accepted normally.
- Wrap/misalign: MEM_WORDS=1024, write to byte addr 0x1004 (offset bits set) then read 0x0000 -> same line returned (aligned, wrapped).
- RD_LATENCY=0 build: read -> ack in cycle 5; reset asserted in XFER -> ack never asserted, all outputs 0 after reset edge.

Source files
------------

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: memory-side responder for data cache line reads (allocate) and writes (write-back).
// Latency: ack in cycle RD_LATENCY+LINE_WORDS+1 counted from the accept cycle; next accept the cycle after ack.
// Backpressure: initiator holds req until ack; req drop or kill in WAIT/XFER aborts with no ack.
// Ports: clk, rst_n (synchronous, active-low);
//        dcache2mem_req_i/_wr_i/_kill_i/_addr_i/_wdata_i : request side, wr/addr/wdata sampled at accept;
//        mem2dcache_rdata_o : last completed read line (word 0 in LSBs); mem2dcache_ack_o : one-cycle
//        completion pulse; busy_o : high whenever a transaction is in flight (including the ack cycle).
module dcache_mem_responder #(
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int RD_LATENCY = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         dcache2mem_req_i,
   input  logic                         dcache2mem_wr_i,
   input  logic                         dcache2mem_kill_i,
   input  logic [ADDR_W-1:0]            dcache2mem_addr_i,
   input  logic [LINE_WORDS*WORD_W-1:0] dcache2mem_wdata_i,
   output logic [LINE_WORDS*WORD_W-1:0] mem2dcache_rdata_o,
   output logic                         mem2dcache_ack_o,
   output logic                         busy_o
);

   localparam int OFF_W  = $clog2(WORD_W / 8);
   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int MEM_AW = $clog2(MEM_WORDS);
   // Counter is loaded with RD_LATENCY-1 so WAIT lasts exactly RD_LATENCY cycles.
   localparam logic [3:0] LAT_INIT = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_ACK} state_t;

   state_t                              state_q, state_d;
   logic                                wr_q, wr_d;
   logic [MEM_AW-1:0]                   base_q, base_d;
   logic [3:0]                          lat_q, lat_d;
   logic [BEAT_W-1:0]                   beat_q, beat_d;
   logic [LINE_WORDS-1:0][WORD_W-1:0]   line_q, line_d;
   logic [LINE_WORDS*WORD_W-1:0]        rdata_q, rdata_d;
   logic                                ack_q, ack_d;
   logic                                busy_q, busy_d;

   // Backing store: deliberately not reset.
   logic [WORD_W-1:0]                   mem [MEM_WORDS];
   logic                                mem_we;
   logic [MEM_AW-1:0]                   mem_idx;
   logic [WORD_W-1:0]                   mem_rword;
   logic                                abort;
   logic                                unused_addr;

   // Base has the in-line word bits cleared, so OR-ing the beat in selects the word.
   assign mem_idx     = base_q | MEM_AW'(beat_q);
   assign mem_rword   = mem[mem_idx];
   assign abort       = dcache2mem_kill_i | ~dcache2mem_req_i;
   // Byte-offset bits and bits above the memory depth are intentionally dropped.
   assign unused_addr = ^dcache2mem_addr_i;

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      base_d  = base_q;
      lat_d   = lat_q;
      beat_d  = beat_q;
      line_d  = line_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      mem_we  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (dcache2mem_req_i && !dcache2mem_kill_i) begin
               wr_d    = dcache2mem_wr_i;
               base_d  = dcache2mem_addr_i[OFF_W +: MEM_AW] & ~MEM_AW'(LINE_WORDS - 1);
               line_d  = dcache2mem_wdata_i;
               lat_d   = LAT_INIT;
               beat_d  = '0;
               state_d = (RD_LATENCY == 0) ? S_XFER : S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (lat_q == 4'd0) begin
               state_d = S_XFER;
               beat_d  = '0;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         S_XFER: begin
            // An aborted beat moves no data; earlier written beats stay in memory.
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  line_d[beat_q] = mem_rword;
               end
               if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
                  state_d = S_ACK;
                  ack_d   = 1'b1;
                  // Read data become visible together with ack; writes leave rdata alone.
                  if (!wr_q) begin
                     rdata_d = line_d;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         S_ACK: begin
            // Transaction is already complete: req and kill are ignored here.
            state_d = S_IDLE;
            lat_d   = '0;
            beat_d  = '0;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         base_q  <= '0;
         lat_q   <= '0;
         beat_q  <= '0;
         line_q  <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         base_q  <= base_d;
         lat_q   <= lat_d;
         beat_q  <= beat_d;
         line_q  <= line_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   // Reset must also suppress a write beat that coincides with it.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[mem_idx] <= line_q[beat_q];
      end
   end

   assign mem2dcache_rdata_o = rdata_q;
   assign mem2dcache_ack_o   = ack_q;
   assign busy_o             = busy_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb_dcache_mem_responder: randomized + directed bench for dcache_mem_responder.
// Main instance uses defaults (RD_LATENCY=2); a second instance covers RD_LATENCY=0.
// A transaction-level model (age since accept, word-array memory) predicts ack/busy/rdata each cycle.
module tb_dcache_mem_responder;
   localparam int L       = 2;
   localparam int W       = 4;
   localparam int ACK_AGE = L + W + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, req, wr, kill;
   logic [31:0]  addr;
   logic [127:0] wdata, rdata;
   logic         ack, busy;

   logic         rst_n0, req0, wr0, kill0;
   logic [31:0]  addr0;
   logic [127:0] wdata0, rdata0;
   logic         ack0, busy0;

   dcache_mem_responder dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .dcache2mem_req_i   (req),
      .dcache2mem_wr_i    (wr),
      .dcache2mem_kill_i  (kill),
      .dcache2mem_addr_i  (addr),
      .dcache2mem_wdata_i (wdata),
      .mem2dcache_rdata_o (rdata),
      .mem2dcache_ack_o   (ack),
      .busy_o             (busy)
   );

   dcache_mem_responder #(.RD_LATENCY(0)) dut0 (
      .clk                (clk),
      .rst_n              (rst_n0),
      .dcache2mem_req_i   (req0),
      .dcache2mem_wr_i    (wr0),
      .dcache2mem_kill_i  (kill0),
      .dcache2mem_addr_i  (addr0),
      .dcache2mem_wdata_i (wdata0),
      .mem2dcache_rdata_o (rdata0),
      .mem2dcache_ack_o   (ack0),
      .busy_o             (busy0)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   task automatic chk_i(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- behavioural model ----------------
   logic [31:0]  mem_m [1024];
   bit           mem_k [1024];
   bit           m_act;
   int           m_age, m_base;
   bit           m_wr;
   logic [31:0]  m_line [4];
   bit           m_lk [4];
   logic [127:0] exp_rd;
   bit           exp_rk [4];
   bit           exp_ack, exp_busy;

   initial begin
      int b, idx;
      for (int i = 0; i < 1024; i++) mem_k[i] = 1'b0;
      m_act = 1'b0; m_age = 0; m_base = 0; m_wr = 1'b0;
      exp_ack = 1'b0; exp_busy = 1'b0; exp_rd = '0;
      for (int w = 0; w < 4; w++) begin exp_rk[w] = 1'b1; m_lk[w] = 1'b0; m_line[w] = '0; end
      forever begin
         @(posedge clk);
         if (rst_n !== 1'b1) begin
            m_act = 1'b0; exp_ack = 1'b0; exp_busy = 1'b0; exp_rd = '0;
            for (int w = 0; w < 4; w++) exp_rk[w] = 1'b1;
         end else begin
            exp_ack = 1'b0;
            if (!m_act) begin
               if (req && !kill) begin
                  m_act  = 1'b1;
                  m_age  = 0;
                  m_wr   = wr;
                  m_base = int'((addr >> 2) % 32'd1024) & ~3;
                  for (int w = 0; w < 4; w++) begin m_line[w] = wdata[w*32 +: 32]; m_lk[w] = 1'b1; end
               end
            end else if (m_age == ACK_AGE) begin
               m_act = 1'b0;
            end else if (kill || !req) begin
               m_act = 1'b0;
            end else if (m_age > L) begin
               b   = m_age - L - 1;
               idx = m_base + b;
               if (m_wr) begin
                  mem_m[idx] = m_line[b]; mem_k[idx] = 1'b1;
               end else begin
                  m_line[b] = mem_m[idx]; m_lk[b] = mem_k[idx];
               end
            end
            if (m_act) begin
               m_age++;
               if (m_age == ACK_AGE) begin
                  exp_ack = 1'b1;
                  if (!m_wr) begin
                     for (int w = 0; w < 4; w++) begin exp_rd[w*32 +: 32] = m_line[w]; exp_rk[w] = m_lk[w]; end
                  end
               end
            end
            exp_busy = m_act;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic [127:0] mask;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk_v("ack", 128'(ack), 128'(exp_ack));
            chk_v("busy", 128'(busy), 128'(exp_busy));
            for (int w = 0; w < 4; w++) mask[w*32 +: 32] = {32{exp_rk[w]}};
            if (mask != '0) chk_v("rdata", rdata & mask, exp_rd & mask);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req = 1'b0; kill = 1'b0;
         @(negedge clk);
      end
   endtask

   // Cycle 0 is the cycle in which req is first presented.
   task automatic txn(input bit w, input logic [31:0] a, input logic [127:0] wd,
                      input int kill_cyc, input int drop_cyc, output int ac, output int ac_abs);
      bit done;
      done = 1'b0; ac = -1; ac_abs = -1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin req = 1'b1; wr = w; addr = a; wdata = wd; end
         kill = (c == kill_cyc);
         if (c == drop_cyc) req = 1'b0;
         @(negedge clk);
         if (c > 0 && ack === 1'b1) begin ac = c; ac_abs = cyc; done = 1'b1; break; end
         if (c == kill_cyc || c == drop_cyc) begin done = 1'b1; break; end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL txn_timeout: no ack within 30 cycles, required ack in cycle %0d", ACK_AGE);
      end
   endtask

   task automatic txn0(input bit w, input logic [31:0] a, input logic [127:0] wd,
                       input int rst_cyc, output int ac);
      ac = -1;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = wd; end
         rst_n0 = (c != rst_cyc);
         if (rst_cyc >= 0 && c == rst_cyc + 1) req0 = 1'b0;
         @(negedge clk);
         if (rst_cyc >= 0 && c == rst_cyc + 1) begin
            chk_v("lat0_rst_ack", 128'(ack0), 128'(0));
            chk_v("lat0_rst_busy", 128'(busy0), 128'(0));
            chk_v("lat0_rst_rdata", rdata0, 128'(0));
         end
         if (c > 0 && ack0 === 1'b1 && ac < 0) begin
            ac = c;
            if (rst_cyc < 0) break;
         end
      end
      @(posedge clk); #1;
      req0 = 1'b0; rst_n0 = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- main sequence ----------------
   localparam logic [127:0] LINE_A  = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] OLD_L   = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
   localparam logic [127:0] NEW_L   = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
   localparam logic [127:0] KILL_RD = 128'hBBBB0003_BBBB0002_AAAA0001_AAAA0000;
   localparam logic [127:0] WRAP_L  = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;
   localparam logic [127:0] LAT0_L  = 128'h0D0D0003_0D0D0002_0D0D0001_0D0D0000;

   initial begin
      int ac, t1, t2, kc, dc;
      logic [31:0]  ra;
      logic [127:0] rd_line;

      rst_n = 1'b0; req = 1'b0; wr = 1'b0; kill = 1'b0; addr = '0; wdata = '0;
      rst_n0 = 1'b0; req0 = 1'b0; wr0 = 1'b0; kill0 = 1'b0; addr0 = '0; wdata0 = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk_v("reset_ack", 128'(ack), 128'(0));
      chk_v("reset_busy", 128'(busy), 128'(0));
      chk_v("reset_rdata", rdata, 128'(0));

      // Fill lines 0..15 so random reads return known data.
      for (int l = 0; l < 16; l++) begin
         txn(1'b1, 32'(l * 16), {$urandom, $urandom, $urandom, $urandom}, -1, -1, ac, t1);
      end

      // Write then read.
      txn(1'b1, 32'h100, LINE_A, -1, -1, ac, t1);
      chk_i("wr_ack_cycle", ac, 7);
      txn(1'b0, 32'h100, 128'(0), -1, -1, ac, t1);
      chk_i("rd_ack_cycle", ac, 7);
      chk_v("rd_line", rdata, LINE_A);

      // Back-to-back write-back then allocate, req held through ack.
      txn(1'b1, 32'h200, {$urandom, $urandom, $urandom, $urandom}, -1, -1, ac, t1);
      txn(1'b0, 32'h300, 128'(0), -1, -1, ac, t2);
      chk_i("b2b_second_ack_cycle", ac, 7);
      chk_i("b2b_ack_spacing", t2 - t1, 8);
      idle(2);

      // Kill during write beat 2 (cycle 5).
      txn(1'b1, 32'h400, OLD_L, -1, -1, ac, t1);
      txn(1'b1, 32'h400, NEW_L, 5, -1, ac, t1);
      chk_i("kill_no_ack", ac, -1);
      idle(1);
      chk_v("kill_busy_next", 128'(busy), 128'(0));
      txn(1'b0, 32'h400, 128'(0), -1, -1, ac, t1);
      chk_v("kill_partial_line", rdata, KILL_RD);

      // Req dropped in WAIT.
      txn(1'b0, 32'h500, 128'(0), -1, 1, ac, t1);
      chk_i("drop_no_ack", ac, -1);
      idle(1);
      chk_v("drop_rdata_kept", rdata, KILL_RD);
      txn(1'b0, 32'h100, 128'(0), -1, -1, ac, t1);
      chk_i("after_drop_ack_cycle", ac, 7);
      chk_v("after_drop_line", rdata, LINE_A);

      // Kill together with req in IDLE, then kill in the ack cycle.
      txn(1'b0, 32'h400, 128'(0), 0, -1, ac, t1);
      idle(1);
      chk_v("idle_kill_busy", 128'(busy), 128'(0));
      txn(1'b0, 32'h400, 128'(0), 7, -1, ac, t1);
      chk_i("ack_cycle_kill_ack", ac, 7);
      chk_v("ack_cycle_kill_line", rdata, KILL_RD);
      idle(1);

      // Misaligned address beyond the memory depth wraps onto line 0.
      txn(1'b1, 32'h1004, WRAP_L, -1, -1, ac, t1);
      txn(1'b0, 32'h0000, 128'(0), -1, -1, ac, t1);
      chk_v("wrap_line", rdata, WRAP_L);

      // Randomized traffic over the preloaded lines.
      for (int n = 0; n < 60; n++) begin
         ra = $urandom;
         ra[11:4] = 8'($urandom_range(0, 15));
         kc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
         dc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : -1;
         rd_line = {$urandom, $urandom, $urandom, $urandom};
         txn(1'($urandom_range(0, 1)), ra, rd_line, kc, dc, ac, t1);
         if (kc < 0 && dc < 0) chk_i("rand_ack_cycle", ac, 7);
         idle(int'($urandom_range(0, 2)));
      end
      idle(3);

      // RD_LATENCY=0 instance.
      @(posedge clk); #1;
      rst_n0 = 1'b1;
      @(negedge clk);
      txn0(1'b1, 32'h20, LAT0_L, -1, ac);
      chk_i("lat0_wr_ack_cycle", ac, 5);
      txn0(1'b0, 32'h20, 128'(0), -1, ac);
      chk_i("lat0_rd_ack_cycle", ac, 5);
      chk_v("lat0_rd_line", rdata0, LAT0_L);
      txn0(1'b0, 32'h20, 128'(0), 2, ac);
      chk_i("lat0_rst_no_ack", ac, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
